tt_pin_reg_responder: RTL and testbench

- Chip-side responder for the host-driven pin interface of a Tiny Tapeout user project.
- An external host (bench or MCU) drives ui_in/uio_in. This block decodes a 4-phase req/ack handshake and serves reads and writes to an internal 8-bit register file.
- Read data is returned on uo_out. Sits inside tt_um_* as the register-access front end.

---
 rtl/tt_pin_pkg.sv | 25 ++
 rtl/tt_sync_edge.sv | 37 +++
 rtl/tt_pin_reg_responder.sv | 142 ++++++++++++++
 tb/tb_tt_pin_reg_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pin_pkg.sv
// Shared types and constants for the Tiny Tapeout host pin register responder.
package tt_pin_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned REQ_BIT = 0;
    localparam int unsigned RNW_BIT = 1;
    localparam int unsigned ACK_BIT = 2;

    localparam logic [BYTE_W-1:0] UIO_OE_MASK = 8'h04;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR_ACK  = 3'd1,
        WAIT_DATA = 3'd2,
        DATA_ACK  = 3'd3,
        RD_ACK    = 3'd4
    } state_t;

    // True when a host address selects an implemented register.
    function automatic logic addr_in_range(input logic [BYTE_W-1:0] addr,
                                           input int unsigned nregs);
        return 32'(addr) < nregs;
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-flop synchronizer for a host-driven strobe with rising-edge detect.
// A rise is only reported once the strobe has been observed low after reset,
// so a strobe already high at reset release never looks like a new request.
module tt_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic req_s,
    output logic req_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   req_prev;
    logic                   armed_q;

    // Synchronizer chain, sample-valid chain, previous value and arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            vld_q    <= '0;
            req_prev <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], req};
            vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            req_prev <= sync_q[SYNC_STAGES-1];
            armed_q  <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
        end
    end

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_prev & armed_q;

endmodule

// File: rtl/tt_pin_reg_responder.sv
// Register-access front end: decodes the host 4-phase req/ack handshake on
// the TT pins and serves byte reads/writes of an internal register file.
module tt_pin_reg_responder
    import tt_pin_pkg::*;
#(
    parameter int unsigned NREGS       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  BAD_RDATA   = 8'hEE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [7:0]           ui_in,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uo_out,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [8*NREGS-1:0]   regs_flat
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [BYTE_W-1:0] addr_q;
    logic              ack_q;
    logic              ack_d;
    logic              addr_ld;
    logic              rd_ld;
    logic              wr_en;
    logic [BYTE_W-1:0] rd_data;
    logic [BYTE_W-1:0] regs_q [NREGS];

    logic req_s;
    logic req_rise;
    logic rnw;
    logic unused_uio;

    assign rnw        = uio_in[RNW_BIT];
    assign unused_uio = &{1'b0, uio_in[7:2]};

    tt_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (uio_in[REQ_BIT]),
        .req_s    (req_s),
        .req_rise (req_rise)
    );

    // Read mux on the live address byte; used only as RD_ACK is entered.
    always_comb begin
        rd_data = BAD_RDATA;
        if (addr_in_range(ui_in, NREGS)) begin
            rd_data = regs_q[ui_in[AW-1:0]];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus datapath strobes; ena low abandons any transaction.
    always_comb begin
        state_d = state_q;
        addr_ld = 1'b0;
        rd_ld   = 1'b0;
        wr_en   = 1'b0;
        ack_d   = 1'b0;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_rise) begin
                        addr_ld = 1'b1;
                        if (rnw) begin
                            rd_ld   = 1'b1;
                            state_d = RD_ACK;
                        end else begin
                            state_d = ADDR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (!req_s) state_d = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (req_rise) begin
                        wr_en   = addr_in_range(addr_q, NREGS);
                        state_d = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (!req_s) state_d = IDLE;
                end
                RD_ACK: begin
                    if (!req_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        ack_d = (state_d == ADDR_ACK) || (state_d == DATA_ACK) || (state_d == RD_ACK);
    end

    // Registered ack, latched address, read-data output and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            addr_q <= '0;
            uo_out <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ack_q <= ack_d;
            if (addr_ld) addr_q <= ui_in;
            if (rd_ld)   uo_out <= rd_data;
            if (wr_en)   regs_q[addr_q[AW-1:0]] <= ui_in;
        end
    end

    // Only the ack bit of the bidirectional bank is ever driven.
    always_comb begin
        uio_out          = '0;
        uio_out[ACK_BIT] = ack_q;
    end

    assign uio_oe = UIO_OE_MASK;

    // Flatten the register file for the core.
    for (genvar gi = 0; gi < int'(NREGS); gi++) begin : g_flat
        assign regs_flat[8*gi +: 8] = regs_q[gi];
    end

endmodule

// File: tb/tb_tt_pin_reg_responder.sv
// Scoreboard bench for tt_pin_reg_responder: a driver plays the host side of
// the handshake and queues expectations from a plain array model; a monitor
// compares on every ack edge and drains directed checks from the driver.
module tb_tt_pin_reg_responder;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [7:0]   ui_in;
    logic [7:0]   uio_in;
    logic [7:0]   uo_out;
    logic [7:0]   uio_out;
    logic [7:0]   uio_oe;
    logic [127:0] regs_flat;

    tt_pin_reg_responder #(
        .NREGS       (16),
        .SYNC_STAGES (2),
        .BAD_RDATA   (8'hEE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .ui_in     (ui_in),
        .uio_in    (uio_in),
        .uo_out    (uo_out),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .regs_flat (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register array and last read result.
    logic [7:0] m_regs [16];
    logic [7:0] m_uo;

    // Scoreboard queues: per ack pulse, expected uo_out and register image.
    logic [7:0]   exp_uo   [$];
    logic [127:0] exp_regs [$];
    // Directed checks captured by the driver, compared by the monitor.
    string        dq_nm    [$];
    logic [127:0] dq_act   [$];
    logic [127:0] dq_exp   [$];

    int   checks;
    int   passes;
    logic stim_done;
    logic ack_seen;

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic dpush(input string nm, input logic [127:0] a, input logic [127:0] e);
        dq_nm.push_back(nm);
        dq_act.push_back(a);
        dq_exp.push_back(e);
    endtask

    task automatic push_exp();
        exp_uo.push_back(m_uo);
        exp_regs.push_back(model_flat());
    endtask

    // One req/ack cycle with latency checks on both ack edges.
    task automatic handshake(input string tag, input logic [7:0] data, input logic rnw_v);
        int n;
        ui_in  = data;
        uio_in = {6'($urandom), rnw_v, 1'b1};
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!uio_out[2] && n < 20);
        dpush({tag, "_ack_rise_latency"}, 128'(n), 128'd3);
        @(negedge clk);
        ui_in     = 8'($urandom);
        uio_in    = {6'($urandom), 1'($urandom), 1'b0};
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (uio_out[2] && n < 20);
        dpush({tag, "_ack_fall_latency"}, 128'(n), 128'd3);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        push_exp();
        handshake("wr_addr", addr, 1'b0);
        if (addr < 8'd16) m_regs[addr[3:0]] = data;
        push_exp();
        handshake("wr_data", data, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] addr);
        m_uo = (addr < 8'd16) ? m_regs[addr[3:0]] : 8'hEE;
        push_exp();
        handshake("rd", addr, 1'b1);
    endtask

    // Driver: host-side stimulus.
    initial begin
        int n;
        logic [7:0] a;
        logic [7:0] d;
        stim_done = 1'b0;
        ack_seen  = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        uio_in    = 8'h01;
        rst_n     = 1'b0;
        m_uo      = 8'h00;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        // Release reset with req already high: no transaction may start.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (uio_out[2]) ack_seen = 1'b1;
        end
        dpush("reqhigh_no_ack", 128'(ack_seen), 128'd0);
        dpush("reset_uo_out", 128'(uo_out), 128'd0);
        dpush("reset_uio_out", 128'(uio_out), 128'd0);
        dpush("uio_oe_const", 128'(uio_oe), 128'h04);
        dpush("reset_regs", regs_flat, 128'd0);
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);

        // Basic write then read-back, with uo_out held across a later write.
        do_write(8'd3, 8'hA5);
        dpush("wr3_regs_flat", regs_flat, model_flat());
        do_read(8'd3);
        dpush("rd3_uo_after_ack", 128'(uo_out), 128'hA5);
        do_write(8'd5, 8'h3C);

        // Out-of-range accesses.
        do_read(8'd20);
        do_write(8'd20, 8'h11);
        dpush("oor_write_regs", regs_flat, model_flat());

        // ena dropped in WAIT_DATA abandons the write to addr 0.
        push_exp();
        handshake("ena_addr", 8'd0, 1'b0);
        ena       = 1'b0;
        ui_in     = 8'h77;
        uio_in[0] = 1'b1;
        ack_seen  = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (uio_out[2]) ack_seen = 1'b1;
        end
        dpush("ena_low_ack", 128'(ack_seen), 128'd0);
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        do_read(8'd0);
        dpush("ena_abandoned_regs", regs_flat, model_flat());

        // Randomized mix, including out-of-range addresses.
        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom_range(0, 23));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_read(a);
            else do_write(a, d);
        end

        // Asynchronous reset during DATA_ACK of a write to addr 1.
        push_exp();
        handshake("rst_addr", 8'd1, 1'b0);
        m_regs[1] = 8'h5A;
        push_exp();
        ui_in     = 8'h5A;
        uio_in[0] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!uio_out[2] && n < 20);
        dpush("rst_data_ack_rise_latency", 128'(n), 128'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        dpush("rst_async_ack", 128'(uio_out), 128'd0);
        dpush("rst_async_regs", regs_flat, 128'd0);
        dpush("rst_async_uo", 128'(uo_out), 128'd0);
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_uo      = 8'h00;
        uio_in[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_read(8'd1);
        do_read(8'd3);
        do_read(8'd5);
        dpush("post_rst_regs", regs_flat, model_flat());

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
    end

    task automatic cmp(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    endtask

    logic         mon_prev_ack;
    logic         mon_pend;
    logic [127:0] mon_regs;

    // Monitor: compares on ack edges and drains directed checks.
    initial begin
        logic [7:0] u;
        checks       = 0;
        passes       = 0;
        mon_prev_ack = 1'b0;
        mon_pend     = 1'b0;
        mon_regs     = '0;
        forever begin
            @(negedge clk);
            while (dq_nm.size() > 0) begin
                cmp(dq_nm.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
            end
            if (!rst_n) begin
                mon_pend     = 1'b0;
                mon_prev_ack = 1'b0;
            end else begin
                if (uio_out[2] && !mon_prev_ack) begin
                    cmp("ack_has_expectation", 128'(exp_uo.size() > 0), 128'd1);
                    if (exp_uo.size() > 0) begin
                        u        = exp_uo.pop_front();
                        mon_regs = exp_regs.pop_front();
                        mon_pend = 1'b1;
                        cmp("sb_uo_out_at_ack", 128'(uo_out), 128'(u));
                    end
                end else if (!uio_out[2] && mon_prev_ack && mon_pend) begin
                    cmp("sb_regs_flat_after_ack", regs_flat, mon_regs);
                    mon_pend = 1'b0;
                end
                mon_prev_ack = uio_out[2];
            end
            if (stim_done && dq_nm.size() == 0) begin
                cmp("sb_drained", 128'(exp_uo.size()), 128'd0);
                $display("%0d/%0d checks passed", passes, checks);
                $finish;
            end
        end
    end

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
